// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the PC fetch unit.
//   - state_e         : fetch FSM states
//   - PW_DEFAULT      : default PC width
//   - I_DEFAULT       : default instruction width
//   - PC_INCR         : sequential PC step in bytes
//   - TIMEOUT_LIMIT   : FETCH cycles without imem_ready before halting
//                       (used only when FETCH_TIMEOUT_EN is defined)
package cpu_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StHalt  = 2'd3
    } state_e;

    localparam int unsigned PW_DEFAULT    = 32;
    localparam int unsigned I_DEFAULT     = 32;
    localparam int unsigned PC_INCR       = 4;
    localparam int unsigned TIMEOUT_LIMIT = 255;

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC computation.
//   pc_i      in  PW  current PC
//   jump_i    in  1   unconditional jump (priority over branch)
//   branch_i  in  2   01=beq, 10=bne, 00/11=no branch
//   zero_i    in  1   ALU zero flag
//   offset_i  in  8   signed word offset
//   pc_next_o out PW  next PC (modulo 2^PW)
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int unsigned PW = PW_DEFAULT
) (
    input  logic [PW-1:0] pc_i,
    input  logic          jump_i,
    input  logic [1:0]    branch_i,
    input  logic          zero_i,
    input  logic [7:0]    offset_i,
    output logic [PW-1:0] pc_next_o
);

    logic          take;
    logic [PW-1:0] pc_seq;
    logic [PW-1:0] off_bytes;

    // Word offset sign-extended and scaled to bytes.
    assign off_bytes = {{(PW - 10){offset_i[7]}}, offset_i, 2'b00};
    assign pc_seq    = pc_i + PW'(PC_INCR);

    always_comb begin
        take = jump_i;
        if (!jump_i) begin
            case (branch_i)
                2'b01:   take = zero_i;
                2'b10:   take = ~zero_i;
                default: take = 1'b0;
            endcase
        end
    end

    assign pc_next_o = take ? (pc_seq + off_bytes) : pc_seq;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction fetch FSM (IDLE -> FETCH <-> EXEC, optional HALT).
//   CLK, RESET          clock, asynchronous active-low reset
//   JUMP/BRANCH/ZERO    control-flow inputs, sampled only in EXEC
//   OFFSET              signed word offset for taken jumps/branches
//   imem_req/imem_addr  instruction memory request, address = PC
//   imem_ready/rdata    memory response, captured in FETCH
//   INSTRUCTION         registered instruction word
//   inst_valid          high during the single EXEC cycle
//   PC                  current program counter
//   fetch_err           sticky timeout flag
// Optional feature: define FETCH_TIMEOUT_EN to enable the FETCH timeout counter
// and the HALT state; otherwise FETCH waits indefinitely and fetch_err is 0.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned I  = I_DEFAULT,
    parameter int unsigned PW = PW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          JUMP,
    input  logic [1:0]    BRANCH,
    input  logic          ZERO,
    input  logic [7:0]    OFFSET,
    output logic          imem_req,
    output logic [PW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [I-1:0]  imem_rdata,
    output logic [I-1:0]  INSTRUCTION,
    output logic          inst_valid,
    output logic [PW-1:0] PC,
    output logic          fetch_err
);

    state_e        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [PW-1:0] pc_next;
    logic [I-1:0]  instr_q, instr_d;

    pc_next_calc #(
        .PW(PW)
    ) u_pc_next_calc (
        .pc_i     (pc_q),
        .jump_i   (JUMP),
        .branch_i (BRANCH),
        .zero_i   (ZERO),
        .offset_i (OFFSET),
        .pc_next_o(pc_next)
    );

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       fetch_err_q, fetch_err_d;
    logic       tmo_expire;

    // The edge that would make the count reach the limit is the last FETCH cycle.
    assign tmo_expire = (tmo_cnt_q == 8'(TIMEOUT_LIMIT - 1));

    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        fetch_err_d = fetch_err_q;
        // Held at zero outside FETCH, so it is clear on every entry.
        if (state_q != StFetch) begin
            tmo_cnt_d = 8'd0;
        end else if (!imem_ready) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
            if (tmo_expire) begin
                fetch_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tmo_cnt_q   <= 8'd0;
            fetch_err_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = StExec;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_expire) begin
                    state_d = StHalt;
                end
`endif
            end
            StExec: begin
                pc_d    = pc_next;
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Outputs decode from state only, so reset clears them without a clock.
    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign inst_valid  = (state_q == StExec);
    assign PC          = pc_q;
    assign INSTRUCTION = instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit.
// Define FETCH_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_pc_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic        JUMP;
    logic [1:0]  BRANCH;
    logic        ZERO;
    logic [7:0]  OFFSET;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] INSTRUCTION;
    logic        inst_valid;
    logic [31:0] PC;
    logic        fetch_err;

    int n_vec  = 0;
    int n_fail = 0;

    pc_fetch_unit dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .JUMP       (JUMP),
        .BRANCH     (BRANCH),
        .ZERO       (ZERO),
        .OFFSET     (OFFSET),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .INSTRUCTION(INSTRUCTION),
        .inst_valid (inst_valid),
        .PC         (PC),
        .fetch_err  (fetch_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reset, release, and stop at the negedge after the first FETCH entry.
    task automatic reset_to_fetch(input logic rdy);
        @(negedge CLK);
        RESET = 1'b0; JUMP = 1'b0; BRANCH = 2'b00; ZERO = 1'b0; OFFSET = 8'h00;
        imem_ready = rdy;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    // From a FETCH negedge: one FETCH->EXEC edge, drive controls in EXEC,
    // one EXEC->FETCH edge. Ends at a negedge in FETCH.
    task automatic instr(input logic j, input logic [1:0] b, input logic z,
                         input logic [7:0] o);
        imem_ready = 1'b1;
        @(negedge CLK);
        JUMP = j; BRANCH = b; ZERO = z; OFFSET = o;
        @(negedge CLK);
        JUMP = 1'b0; BRANCH = 2'b00; ZERO = 1'b0; OFFSET = 8'h00;
    endtask

    task automatic test_reset();
        RESET = 1'b0; JUMP = 1'b0; BRANCH = 2'b00; ZERO = 1'b0; OFFSET = 8'h00;
        imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
        repeat (2) @(negedge CLK);
        n_vec++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
        n_vec++; if (INSTRUCTION !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", INSTRUCTION, 32'h0); end
        n_vec++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_vec++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_vec++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        logic [31:0] exp_instr;
        base = 32'h1111_0000;
        @(negedge CLK);
        RESET = 1'b0; imem_ready = 1'b1; imem_rdata = base;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        n_vec++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_req: got %b want 0", imem_req); end
        for (int k = 1; k <= 6; k++) begin
            imem_rdata = base + 32'(k - 1);
            @(negedge CLK);
            if (k == 1) exp_instr = 32'h0;
            else if (k % 2 == 0) exp_instr = base + 32'(k - 1);
            else exp_instr = base + 32'(k - 2);
            n_vec++; if (inst_valid !== (k % 2 == 0)) begin n_fail++; $display("FAIL b2b_valid c%0d: got %b want %b", k, inst_valid, (k % 2 == 0)); end
            n_vec++; if (imem_req !== (k % 2 == 1)) begin n_fail++; $display("FAIL b2b_req c%0d: got %b want %b", k, imem_req, (k % 2 == 1)); end
            n_vec++; if (INSTRUCTION !== exp_instr) begin n_fail++; $display("FAIL b2b_instr c%0d: got %h want %h", k, INSTRUCTION, exp_instr); end
            if (k % 2 == 1) begin
                n_vec++; if (imem_addr !== 32'(4 * ((k - 1) / 2))) begin n_fail++; $display("FAIL b2b_addr c%0d: got %h want %h", k, imem_addr, 32'(4 * ((k - 1) / 2))); end
            end
        end
    endtask

    task automatic test_jump();
        reset_to_fetch(1'b1);
        instr(1'b1, 2'b00, 1'b0, 8'h03);
        n_vec++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL jump_to_10: got %h want %h", imem_addr, 32'h10); end
        instr(1'b1, 2'b00, 1'b0, 8'hFE);
        n_vec++; if (imem_addr !== 32'h0C) begin n_fail++; $display("FAIL jump_back: got %h want %h", imem_addr, 32'h0C); end
        n_vec++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL jump_req: got %b want 1", imem_req); end
    endtask

    task automatic test_branch();
        reset_to_fetch(1'b1);
        instr(1'b1, 2'b00, 1'b0, 8'h07);
        n_vec++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL br_setup: got %h want %h", imem_addr, 32'h20); end
        instr(1'b0, 2'b01, 1'b1, 8'h03);
        n_vec++; if (imem_addr !== 32'h30) begin n_fail++; $display("FAIL beq_taken: got %h want %h", imem_addr, 32'h30); end
        instr(1'b1, 2'b00, 1'b0, 8'hFB);
        instr(1'b0, 2'b01, 1'b0, 8'h03);
        n_vec++; if (imem_addr !== 32'h24) begin n_fail++; $display("FAIL beq_not_taken: got %h want %h", imem_addr, 32'h24); end
        instr(1'b1, 2'b00, 1'b0, 8'hFE);
        instr(1'b0, 2'b10, 1'b1, 8'h03);
        n_vec++; if (imem_addr !== 32'h24) begin n_fail++; $display("FAIL bne_not_taken: got %h want %h", imem_addr, 32'h24); end
        instr(1'b1, 2'b00, 1'b0, 8'hFE);
        instr(1'b0, 2'b10, 1'b0, 8'h03);
        n_vec++; if (imem_addr !== 32'h30) begin n_fail++; $display("FAIL bne_taken: got %h want %h", imem_addr, 32'h30); end
        instr(1'b1, 2'b00, 1'b0, 8'hFB);
        instr(1'b0, 2'b11, 1'b1, 8'h03);
        n_vec++; if (imem_addr !== 32'h24) begin n_fail++; $display("FAIL br11_z1: got %h want %h", imem_addr, 32'h24); end
        instr(1'b0, 2'b11, 1'b0, 8'h03);
        n_vec++; if (imem_addr !== 32'h28) begin n_fail++; $display("FAIL br11_z0: got %h want %h", imem_addr, 32'h28); end
        instr(1'b1, 2'b00, 1'b0, 8'hFD);
        n_vec++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL br_return: got %h want %h", imem_addr, 32'h20); end
        instr(1'b1, 2'b10, 1'b1, 8'h01);
        n_vec++; if (imem_addr !== 32'h28) begin n_fail++; $display("FAIL jump_over_bne: got %h want %h", imem_addr, 32'h28); end
    endtask

    task automatic test_wrap();
        reset_to_fetch(1'b1);
        instr(1'b1, 2'b00, 1'b0, 8'hFE);
        n_vec++; if (PC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h want %h", PC, 32'hFFFF_FFFC); end
        instr(1'b0, 2'b00, 1'b0, 8'h00);
        n_vec++; if (PC !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", PC, 32'h0); end
        n_vec++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b want 0", fetch_err); end
    endtask

    task automatic test_ignore_outside_exec();
        reset_to_fetch(1'b0);
        JUMP = 1'b1; BRANCH = 2'b01; ZERO = 1'b1; OFFSET = 8'h40;
        repeat (3) @(negedge CLK);
        n_vec++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL ign_fetch_addr: got %h want %h", imem_addr, 32'h0); end
        n_vec++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ign_fetch_req: got %b want 1", imem_req); end
        imem_ready = 1'b1;
        @(negedge CLK);
        n_vec++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL ign_exec_valid: got %b want 1", inst_valid); end
        JUMP = 1'b0; BRANCH = 2'b00; ZERO = 1'b0; OFFSET = 8'h00;
        @(negedge CLK);
        n_vec++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL ign_next_addr: got %h want %h", imem_addr, 32'h4); end
    endtask

    task automatic test_reset_mid_fetch();
        reset_to_fetch(1'b1);
        imem_rdata = 32'h5A5A_0001;
        instr(1'b1, 2'b00, 1'b0, 8'h07);
        imem_ready = 1'b0;
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        n_vec++; if (PC !== 32'h0) begin n_fail++; $display("FAIL rmf_pc: got %h want %h", PC, 32'h0); end
        n_vec++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rmf_addr: got %h want %h", imem_addr, 32'h0); end
        n_vec++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rmf_req: got %b want 0", imem_req); end
        n_vec++; if (INSTRUCTION !== 32'h0) begin n_fail++; $display("FAIL rmf_instr: got %h want %h", INSTRUCTION, 32'h0); end
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        n_vec++; if (INSTRUCTION !== 32'h0) begin n_fail++; $display("FAIL rmf_late_ready: got %h want %h", INSTRUCTION, 32'h0); end
        imem_ready = 1'b0; RESET = 1'b1;
        @(negedge CLK);
        n_vec++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rmf_refetch_req: got %b want 1", imem_req); end
        n_vec++; if (INSTRUCTION !== 32'h0) begin n_fail++; $display("FAIL rmf_refetch_instr: got %h want %h", INSTRUCTION, 32'h0); end
        @(negedge CLK);
        n_vec++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_wait_valid: got %b want 0", inst_valid); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        imem_rdata = 32'h7777_7777;
        reset_to_fetch(1'b0);
        repeat (254) @(negedge CLK);
        n_vec++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL tmo_last_fetch_req: got %b want 1", imem_req); end
        n_vec++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL tmo_last_fetch_err: got %b want 0", fetch_err); end
        @(negedge CLK);
        n_vec++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL tmo_halt_req: got %b want 0", imem_req); end
        n_vec++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL tmo_halt_err: got %b want 1", fetch_err); end
        imem_ready = 1'b1;
        repeat (3) @(negedge CLK);
        n_vec++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_ready_valid: got %b want 0", inst_valid); end
        n_vec++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL tmo_ready_req: got %b want 0", imem_req); end
        n_vec++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", fetch_err); end
        n_vec++; if (INSTRUCTION !== 32'h0) begin n_fail++; $display("FAIL tmo_instr: got %h want %h", INSTRUCTION, 32'h0); end
        #2 RESET = 1'b0;
        #1;
        n_vec++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL tmo_reset_err: got %b want 0", fetch_err); end
        @(negedge CLK);
        RESET = 1'b1;
    endtask
`else
    task automatic test_no_timeout();
        reset_to_fetch(1'b0);
        repeat (300) @(negedge CLK);
        n_vec++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL notmo_req: got %b want 1", imem_req); end
        n_vec++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL notmo_err: got %b want 0", fetch_err); end
        imem_ready = 1'b1;
        @(negedge CLK);
        n_vec++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL notmo_exec: got %b want 1", inst_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_jump();
        test_branch();
        test_wrap();
        test_ignore_outside_exec();
        test_reset_mid_fetch();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
